// File: rtl/bcd_display_scanner_if.sv
// Bus between the decade counter / display board and the BCD scanner.
interface bcd_display_scanner_if;
    logic [3:0] units_in;
    logic       freeze;
    logic [6:0] seg;
    logic [3:0] an;
    logic       carry_out;
    logic       err;

    modport master (output units_in, freeze, input seg, an, carry_out, err);
    modport slave  (input units_in, freeze, output seg, an, carry_out, err);
endinterface

// File: rtl/bcd_display_scanner.sv
// Cascades the decade counter's units wraps into a 4-digit BCD value and
// scans it onto a time-multiplexed seven-segment display.
module bcd_display_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic clk,
    input logic rst,
    bcd_display_scanner_if.slave bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [3:0]    units_q;
    logic [3:0]    prev_q;
    logic [3:0]    tens;
    logic [3:0]    hundreds;
    logic [3:0]    thousands;
    logic [15:0]   disp;
    logic [PW-1:0] prescaler;
    logic [1:0]    scan_idx;
    logic          wrap;
    logic          blank;
    logic [3:0]    cur_digit;

    function automatic logic [6:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 7'h3F;
            4'd1:    encode = 7'h06;
            4'd2:    encode = 7'h5B;
            4'd3:    encode = 7'h4F;
            4'd4:    encode = 7'h66;
            4'd5:    encode = 7'h6D;
            4'd6:    encode = 7'h7D;
            4'd7:    encode = 7'h07;
            4'd8:    encode = 7'h7F;
            4'd9:    encode = 7'h6F;
            default: encode = 7'h79;
        endcase
    endfunction

    // Both samples must be valid BCD for this to match, so invalid values never wrap.
    assign wrap = (prev_q == 4'd9) && (units_q == 4'd0);

    always_comb begin
        cur_digit = 4'd0;
        blank     = 1'b0;
        case (scan_idx)
            2'd0: cur_digit = disp[3:0];
            2'd1: begin
                cur_digit = disp[7:4];
                blank     = BLANK_LZ && (disp[15:4] == 12'd0);
            end
            2'd2: begin
                cur_digit = disp[11:8];
                blank     = BLANK_LZ && (disp[15:8] == 8'd0);
            end
            2'd3: begin
                cur_digit = disp[15:12];
                blank     = BLANK_LZ && (disp[15:12] == 4'd0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            units_q       <= 4'd0;
            prev_q        <= 4'd0;
            tens          <= 4'd0;
            hundreds      <= 4'd0;
            thousands     <= 4'd0;
            disp          <= 16'd0;
            prescaler     <= '0;
            scan_idx      <= 2'd0;
            bus.seg       <= 7'h3F;
            bus.an        <= 4'b0001;
            bus.carry_out <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            units_q <= bus.units_in;
            prev_q  <= units_q;

            if (wrap) begin
                if (tens == 4'd9) begin
                    tens <= 4'd0;
                    if (hundreds == 4'd9) begin
                        hundreds  <= 4'd0;
                        thousands <= (thousands == 4'd9) ? 4'd0 : thousands + 4'd1;
                    end else begin
                        hundreds <= hundreds + 4'd1;
                    end
                end else begin
                    tens <= tens + 4'd1;
                end
            end
            bus.carry_out <= wrap && (tens == 4'd9) && (hundreds == 4'd9) && (thousands == 4'd9);
            bus.err       <= bus.err | (units_q > 4'd9);

            if (!bus.freeze)
                disp <= {thousands, hundreds, tens, units_q};

            // an/seg follow the index one edge late so they always switch together.
            if (prescaler == PRESC_LAST) begin
                prescaler <= '0;
                scan_idx  <= scan_idx + 2'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
            bus.an  <= 4'b0001 << scan_idx;
            bus.seg <= blank ? 7'h00 : encode(cur_digit);
        end
    end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: two instances (SCAN_DIV=4/blanking, SCAN_DIV=1/no blanking)
// share stimulus and are checked every cycle against a wrap-count model.
module tb_bcd_display_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] units_in = 4'd0;
    logic       freeze = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    int         carry_count = 0;

    bcd_display_scanner_if if_a ();
    bcd_display_scanner_if if_b ();

    assign if_a.units_in = units_in;
    assign if_a.freeze   = freeze;
    assign if_b.units_in = units_in;
    assign if_b.freeze   = freeze;

    bcd_display_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    bcd_display_scanner #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    initial forever #5 clk = ~clk;

    // Model state: the value is just the number of wraps seen, split into digits by arithmetic.
    bit         m_valid = 1'b0;
    int         m_s1, m_s2, m_wraps, m_n;
    int         m_disp [4];
    bit         m_carry, m_err, m_wrap;
    logic [6:0] exp_seg_a, exp_seg_b;
    logic [3:0] exp_an_a, exp_an_b;

    function automatic logic [6:0] seg_table(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h79;
        endcase
    endfunction

    function automatic logic [6:0] expect_seg(input int idx, input bit blz);
        bit all_zero;
        all_zero = 1'b1;
        for (int j = idx; j < 4; j++)
            if (m_disp[j] != 0) all_zero = 1'b0;
        if (blz && idx >= 1 && all_zero) return 7'h00;
        return seg_table(m_disp[idx]);
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b1;
            m_s1 = 0; m_s2 = 0; m_wraps = 0; m_n = 0;
            for (int i = 0; i < 4; i++) m_disp[i] = 0;
            m_carry = 1'b0; m_err = 1'b0;
            exp_an_a = 4'b0001; exp_an_b = 4'b0001;
            exp_seg_a = 7'h3F;  exp_seg_b = 7'h3F;
        end else if (m_valid) begin
            exp_an_a  = 4'(1 << ((m_n / 4) % 4));
            exp_seg_a = expect_seg((m_n / 4) % 4, 1'b1);
            exp_an_b  = 4'(1 << (m_n % 4));
            exp_seg_b = expect_seg(m_n % 4, 1'b0);
            m_wrap  = (m_s2 == 9) && (m_s1 == 0);
            m_carry = m_wrap && (m_wraps % 1000 == 999);
            m_err   = m_err || (m_s1 > 9);
            if (!freeze) begin
                m_disp[0] = m_s1;
                m_disp[1] = m_wraps % 10;
                m_disp[2] = (m_wraps / 10) % 10;
                m_disp[3] = (m_wraps / 100) % 10;
            end
            if (m_wrap) m_wraps++;
            m_s2 = m_s1;
            m_s1 = int'(units_in);
            m_n++;
        end
        #1;
        if (m_valid) begin
            checkOutput("a_an",    if_a.an,        exp_an_a);
            checkOutput("a_seg",   if_a.seg,       exp_seg_a);
            checkOutput("a_carry", if_a.carry_out, m_carry);
            checkOutput("a_err",   if_a.err,       m_err);
            checkOutput("b_an",    if_b.an,        exp_an_b);
            checkOutput("b_seg",   if_b.seg,       exp_seg_b);
            checkOutput("b_carry", if_b.carry_out, m_carry);
            checkOutput("b_err",   if_b.err,       m_err);
        end
    end

    always @(negedge clk)
        if (if_a.carry_out === 1'b1) carry_count++;

    task automatic applyStimulus(input logic [3:0] u, input logic f);
        @(negedge clk);
        units_in = u;
        freeze   = f;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1; units_in = 4'd0; freeze = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        carry_count = 0;
    endtask

    task automatic doWraps(input int n);
        repeat (n) begin
            applyStimulus(4'd9, freeze);
            applyStimulus(4'd0, freeze);
        end
    endtask

    // Observes a full scan rotation of both instances and compares each digit's pattern.
    task automatic checkDigits(input string tag, input logic [3:0][7:0] exp_a, input logic [3:0][7:0] exp_b);
        logic [3:0][7:0] got_a, got_b;
        got_a = '1;
        got_b = '1;
        repeat (4) @(negedge clk);
        repeat (17) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (if_a.an[i] === 1'b1) got_a[i] = {1'b0, if_a.seg};
                if (if_b.an[i] === 1'b1) got_b[i] = {1'b0, if_b.seg};
            end
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_a_dig%0d", tag, i), got_a[i], exp_a[i]);
            checkOutput($sformatf("%s_b_dig%0d", tag, i), got_b[i], exp_b[i]);
        end
    endtask

    logic [3:0] an_hist [25];
    int         last_change, changes;

    initial begin
        doReset();
        checkOutput("rst_a_an", if_a.an, 4'b0001);
        checkOutput("rst_a_seg", if_a.seg, 7'h3F);
        checkOutput("rst_a_carry", if_a.carry_out, 0);
        checkOutput("rst_a_err", if_a.err, 0);
        checkOutput("rst_b_an", if_b.an, 4'b0001);
        checkOutput("rst_b_seg", if_b.seg, 7'h3F);
        repeat (3) applyStimulus(4'd0, 1'b0);
        checkDigits("reset", {8'h00, 8'h00, 8'h00, 8'h3F}, {8'h3F, 8'h3F, 8'h3F, 8'h3F});

        $display("[TB] cascade: 23 decades then hold 7");
        repeat (23)
            for (int v = 1; v <= 10; v++) applyStimulus(4'(v % 10), 1'b0);
        applyStimulus(4'd7, 1'b0);
        checkDigits("cascade", {8'h00, 8'h5B, 8'h4F, 8'h07}, {8'h3F, 8'h5B, 8'h4F, 8'h07});
        checkOutput("cascade_model_wraps", m_wraps, 23);
        checkOutput("cascade_carry_count", carry_count, 0);

        $display("[TB] rollover");
        doReset();
        doWraps(999);
        checkDigits("pre_roll", {8'h6F, 8'h6F, 8'h6F, 8'h3F}, {8'h6F, 8'h6F, 8'h6F, 8'h3F});
        checkOutput("pre_roll_carry_count", carry_count, 0);
        doWraps(1);
        checkDigits("post_roll", {8'h00, 8'h00, 8'h00, 8'h3F}, {8'h3F, 8'h3F, 8'h3F, 8'h3F});
        checkOutput("roll_carry_cycles", carry_count, 1);

        $display("[TB] invalid input");
        doReset();
        doWraps(2);
        applyStimulus(4'd3, 1'b0);
        applyStimulus(4'd9, 1'b0);
        applyStimulus(4'hB, 1'b0);
        @(negedge clk);
        checkOutput("err_pre_a", if_a.err, 0);
        @(negedge clk);
        checkOutput("err_set_a", if_a.err, 1);
        checkOutput("err_set_b", if_b.err, 1);
        checkDigits("invalid", {8'h00, 8'h00, 8'h5B, 8'h79}, {8'h3F, 8'h3F, 8'h5B, 8'h79});
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd5, 1'b0);
        checkDigits("recover", {8'h00, 8'h00, 8'h5B, 8'h6D}, {8'h3F, 8'h3F, 8'h5B, 8'h6D});
        checkOutput("err_sticky_a", if_a.err, 1);
        checkOutput("err_sticky_b", if_b.err, 1);
        doReset();
        checkOutput("err_cleared_a", if_a.err, 0);

        $display("[TB] freeze");
        doWraps(4);
        applyStimulus(4'd2, 1'b0);
        checkDigits("show42", {8'h00, 8'h00, 8'h66, 8'h5B}, {8'h3F, 8'h3F, 8'h66, 8'h5B});
        applyStimulus(4'd2, 1'b1);
        doWraps(3);
        applyStimulus(4'd2, 1'b1);
        checkDigits("frozen", {8'h00, 8'h00, 8'h66, 8'h5B}, {8'h3F, 8'h3F, 8'h66, 8'h5B});
        applyStimulus(4'd2, 1'b0);
        checkDigits("thawed", {8'h00, 8'h00, 8'h07, 8'h5B}, {8'h3F, 8'h3F, 8'h07, 8'h5B});

        $display("[TB] scan 0047");
        doReset();
        doWraps(4);
        applyStimulus(4'd7, 1'b0);
        checkDigits("scan47", {8'h00, 8'h00, 8'h66, 8'h07}, {8'h3F, 8'h3F, 8'h66, 8'h07});
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            an_hist[k] = if_a.an;
        end
        last_change = -1;
        changes = 0;
        for (int k = 1; k < 25; k++) begin
            if (an_hist[k] != an_hist[k-1]) begin
                checkOutput("scan_rotate", an_hist[k], {an_hist[k-1][2:0], an_hist[k-1][3]});
                if (last_change >= 0) checkOutput("scan_dwell", k - last_change, 4);
                last_change = k;
                changes++;
            end
        end
        checkOutput("scan_changes_ge5", (changes >= 5) ? 1 : 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
